// File: rtl/amplitude_meter.sv
`timescale 1ns/1ps
// amplitude_meter: windowed peak-to-peak of ADC codes, scaled to input-referred microvolts.
// Optional feature macro AMP_AVG4_EN: report the running mean of the last four window results.
module amplitude_meter #(
    parameter int          WINDOW_LOG2 = 9,
    parameter logic [11:0] OVR_THRESH  = 12'd3941
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [11:0] adc_data,
    input  logic [1:0]  gain_sel,
    input  logic        gain_stable,
    output logic [19:0] vpp_uv,
    output logic        vpp_valid,
    output logic        out_of_range,
    output logic        window_abort
);
    localparam int            CW       = WINDOW_LOG2 + 1;
    localparam logic [CW-1:0] LAST_IDX = {1'b0, {WINDOW_LOG2{1'b1}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_MULT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]    state;
    logic [1:0]    g_lat;
    logic [11:0]   peak;
    logic [11:0]   valley;
    logic [CW-1:0] count;
    logic          ovr;
    logic [27:0]   prod;

    logic [11:0]   span;
    logic [28:0]   rounded;
    logic [20:0]   scaled;
    logic [19:0]   win_uv;
    logic          abort;

    // Q8 microvolts per ADC code for each relay gain.
    function automatic logic [15:0] k_of(input logic [1:0] g);
        case (g)
            2'd0:    k_of = 16'd41667;
            2'd1:    k_of = 16'd19231;
            2'd2:    k_of = 16'd9259;
            default: k_of = 16'd4273;
        endcase
    endfunction

    // NOTE: every variable here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        span    = peak - valley;
        rounded = {1'b0, prod} + 29'd128;
        scaled  = rounded[28:8];
        win_uv  = scaled[20] ? 20'hFFFFF : scaled[19:0];
        abort   = (state == S_ACCUM) && (!gain_stable || (gain_sel != g_lat));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            g_lat        <= 2'd0;
            peak         <= 12'd0;
            valley       <= 12'hFFF;
            count        <= '0;
            ovr          <= 1'b0;
            prod         <= 28'd0;
            window_abort <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch sees pre-edge state.
            window_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gain_stable) begin
                        g_lat  <= gain_sel;
                        peak   <= 12'd0;
                        valley <= 12'hFFF;
                        count  <= '0;
                        ovr    <= 1'b0;
                        state  <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (abort) begin
                        window_abort <= 1'b1;
                        state        <= S_IDLE;
                    end else if (sample_valid) begin
                        peak   <= (adc_data > peak)   ? adc_data : peak;
                        valley <= (adc_data < valley) ? adc_data : valley;
                        ovr    <= ovr | (adc_data >= OVR_THRESH);
                        count  <= count + 1'b1;
                        if (count == LAST_IDX) state <= S_MULT;
                    end
                end
                S_MULT: begin
                    prod  <= {16'd0, span} * {12'd0, k_of(g_lat)};
                    state <= S_OUT;
                end
                default: begin
                    // Result is taken from prod/ovr this cycle; restart reuses the live gain.
                    if (gain_stable) begin
                        g_lat  <= gain_sel;
                        peak   <= 12'd0;
                        valley <= 12'hFFF;
                        count  <= '0;
                        ovr    <= 1'b0;
                        state  <= S_ACCUM;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef AMP_AVG4_EN
    logic [19:0] hist [4];
    logic [3:0]  hist_ovr;
    logic [21:0] sum;
    logic [2:0]  fill;
    logic        pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the four-entry history is plain flops, so it is reset with the rest of the state.
            for (int i = 0; i < 4; i++) hist[i] <= 20'd0;
            hist_ovr     <= 4'd0;
            sum          <= 22'd0;
            fill         <= 3'd0;
            pend         <= 1'b0;
            vpp_uv       <= 20'd0;
            vpp_valid    <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            pend      <= 1'b0;
            vpp_valid <= pend;
            if (pend) begin
                vpp_uv       <= sum[21:2];
                out_of_range <= |hist_ovr;
            end
            if (abort) begin
                for (int i = 0; i < 4; i++) hist[i] <= 20'd0;
                hist_ovr <= 4'd0;
                sum      <= 22'd0;
                fill     <= 3'd0;
            end else if (state == S_OUT) begin
                hist[0]  <= win_uv;
                hist[1]  <= hist[0];
                hist[2]  <= hist[1];
                hist[3]  <= hist[2];
                hist_ovr <= {hist_ovr[2:0], ovr};
                sum      <= sum + {2'b00, win_uv} - {2'b00, hist[3]};
                fill     <= (fill == 3'd4) ? fill : fill + 1'b1;
                pend     <= (fill >= 3'd3);
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpp_uv       <= 20'd0;
            vpp_valid    <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            vpp_valid <= (state == S_OUT);
            if (state == S_OUT) begin
                vpp_uv       <= win_uv;
                out_of_range <= ovr;
            end
        end
    end
`endif

endmodule

// File: tb/tb_amplitude_meter.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for amplitude_meter; the reference model works per window from
// the measurement rules (extremes, gain constant, rounding, optional four-window mean).
module tb_amplitude_meter;
    localparam int WIN = 512;
`ifdef AMP_AVG4_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int M_ALT   = 0;
    localparam int M_RAND  = 1;
    localparam int M_CONST = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] adc_data = 12'd0;
    logic [1:0]  gain_sel = 2'd0;
    logic        gain_stable = 1'b0;
    logic [19:0] vpp_uv;
    logic        vpp_valid;
    logic        out_of_range;
    logic        window_abort;

    amplitude_meter dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .adc_data(adc_data),
        .gain_sel(gain_sel), .gain_stable(gain_stable), .vpp_uv(vpp_uv),
        .vpp_valid(vpp_valid), .out_of_range(out_of_range), .window_abort(window_abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int uv;
        bit ovr;
        int cyc_due;
    } exp_t;

    exp_t sb[$];
    int   hist_uv[$];
    bit   hist_ovr[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   abort_seen = 0;
    int   abort_exp = 0;
    int   last_uv = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic int k_of(input int g);
        case (g)
            0:       return 41667;
            1:       return 19231;
            2:       return 9259;
            default: return 4273;
        endcase
    endfunction

    function automatic int win_result(input int span, input int g);
        longint r;
        r = (longint'(span) * k_of(g) + 128) >>> 8;
        if (r > 64'hFFFFF) r = 64'hFFFFF;
        return int'(r);
    endfunction

    task automatic model_window(input int uv, input bit o, input int at_cyc);
        exp_t e;
`ifdef AMP_AVG4_EN
        int s;
        bit oo;
        hist_uv.push_back(uv);
        hist_ovr.push_back(o);
        if (hist_uv.size() > 4) begin
            void'(hist_uv.pop_front());
            void'(hist_ovr.pop_front());
        end
        if (hist_uv.size() == 4) begin
            s = 0;
            oo = 1'b0;
            foreach (hist_uv[i]) begin
                s += hist_uv[i];
                oo |= hist_ovr[i];
            end
            e.uv = s >> 2;
            e.ovr = oo;
            e.cyc_due = at_cyc + LAT;
            sb.push_back(e);
        end
`else
        e.uv = uv;
        e.ovr = o;
        e.cyc_due = at_cyc + LAT;
        sb.push_back(e);
`endif
    endtask

    task automatic model_clear();
        hist_uv.delete();
        hist_ovr.delete();
    endtask

    task automatic tick(input bit v, input int d);
        sample_valid = v;
        adc_data = d[11:0];
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input int g);
        gain_sel = g[1:0];
        gain_stable = 1'b1;
        tick(0, 0);
    endtask

    // Full window, then the two cycles in which the meter ignores samples.
    task automatic run_window(input int g, input int mode, input int lo, input int hi,
                              input int ovr_idx, input bit quiet_end);
        int mx = 0;
        int mn = 4095;
        bit o = 1'b0;
        int d;
        for (int i = 0; i < WIN; i++) begin
            if ($urandom_range(3) == 0) repeat ($urandom_range(2, 1)) tick(0, int'($urandom_range(4095)));
            case (mode)
                M_ALT:   d = (i % 2 == 1) ? hi : lo;
                M_RAND:  d = int'($urandom_range(hi, lo));
                default: d = lo;
            endcase
            if (i == ovr_idx) d = 3941;
            if (d > mx) mx = d;
            if (d < mn) mn = d;
            if (d >= 3941) o = 1'b1;
            tick(1, d);
        end
        model_window(win_result(mx - mn, g), o, cyc);
        tick(1, 4095);
        if (quiet_end) gain_stable = 1'b0;
        tick(1, 0);
        if (quiet_end) tick(0, 0);
    endtask

    task automatic end_session_abort();
        gain_stable = 1'b0;
        tick(0, 0);
        check("session_end_abort", window_abort, 1);
        abort_exp++;
        model_clear();
        tick(0, 0);
    endtask

    // kind 0: gain_stable drops; kind 1: gain_sel changes to new_g. Both coincide with a sample.
    task automatic partial(input int n, input int kind, input int new_g);
        for (int i = 0; i < n; i++) tick(1, int'($urandom_range(4095)));
        if (kind == 0) gain_stable = 1'b0;
        else gain_sel = new_g[1:0];
        tick(1, int'($urandom_range(4095)));
        check("abort_pulse", window_abort, 1);
        check("no_valid_on_abort", vpp_valid, 0);
        abort_exp++;
        model_clear();
        tick(0, 0);
        check("abort_one_cycle", window_abort, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (window_abort) abort_seen++;
            if (vpp_valid) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_valid: got pulse with vpp_uv=%0d at cycle %0d, required none",
                             vpp_uv, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("vpp_uv", vpp_uv, e.uv);
                    check("out_of_range", out_of_range, e.ovr);
                    check("latency_cycle", cyc, e.cyc_due);
                    last_uv = e.uv;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, lo, hi;
        tick(0, 0);
        tick(0, 0);
        check("reset_vpp_uv", vpp_uv, 0);
        check("reset_vpp_valid", vpp_valid, 0);
        check("reset_out_of_range", out_of_range, 0);
        check("reset_window_abort", window_abort, 0);
        rst_n = 1'b1;
        tick(0, 0);

        start_session(0);
        run_window(0, M_ALT, 1000, 3000, -1, 0);
        run_window(0, M_RAND, 500, 3500, -1, 0);
        end_session_abort();

        start_session(3);
        run_window(3, M_ALT, 1000, 3000, -1, 0);
        run_window(3, M_RAND, 0, 4095, -1, 0);
        end_session_abort();

        start_session(1);
        run_window(1, M_ALT, 1500, 2500, 100, 0);
        run_window(1, M_CONST, 2048, 2048, -1, 1);

        start_session(2);
        partial(300, 0, 0);
        start_session(2);
        run_window(2, M_CONST, 2048, 2048, -1, 0);
        end_session_abort();

        start_session(3);
        partial(WIN - 1, 0, 0);

        start_session(0);
        run_window(0, M_RAND, 100, 3000, -1, 0);
        partial(150, 1, 1);
        run_window(1, M_ALT, 1000, 3000, -1, 0);
        run_window(1, M_RAND, 200, 4000, -1, 0);
        end_session_abort();

        for (int s = 0; s < 2; s++) begin
            g = int'($urandom_range(3));
            start_session(g);
            for (int w = 0; w < 5; w++) begin
                lo = int'($urandom_range(2000));
                hi = lo + int'($urandom_range(4095 - lo));
                run_window(g, M_RAND, lo, hi, -1, 0);
            end
            end_session_abort();
        end

        start_session(2);
        for (int w = 0; w < 3; w++) run_window(2, M_RAND, 1000, 3900, -1, 0);
        for (int i = 0; i < 200; i++) tick(1, int'($urandom_range(4095)));
        #2;
        rst_n = 1'b0;
        gain_stable = 1'b0;
        #1;
        check("midreset_vpp_uv", vpp_uv, 0);
        check("midreset_vpp_valid", vpp_valid, 0);
        check("midreset_out_of_range", out_of_range, 0);
        check("midreset_window_abort", window_abort, 0);
        model_clear();
        tick(0, 0);
        tick(0, 0);
        rst_n = 1'b1;
        tick(0, 0);

        start_session(2);
        for (int w = 0; w < 3; w++) run_window(2, M_RAND, 0, 3000, -1, 0);
        run_window(2, M_ALT, 1200, 3300, -1, 1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick(0, 0);
        check("scoreboard_drained", sb.size(), 0);
        check("abort_count", abort_seen, abort_exp);
        repeat (3) tick(0, 0);
        check("vpp_uv_held", vpp_uv, last_uv);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
